// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver: one digit per refresh slot, tear-free
// frame-aligned updates, per-digit blank/dp, leading-zero suppression, anti-ghost gap.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp,
    input  logic [DIGITS-1:0]   blank,
    input  logic                lz_en,
    input  logic                load,
    output logic [6:0]          seg,
    output logic                dp_n,
    output logic [DIGITS-1:0]   an,
    output logic                frame_start
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef struct packed {
        logic [DIGITS-1:0][3:0] val;
        logic [DIGITS-1:0]      dp;
        logic [DIGITS-1:0]      blank;
        logic                   lz;
    } disp_t;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
        endcase
    endfunction

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              pend_q, pend_d;
    disp_t             shadow_q, shadow_d, active_q, active_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_n_q, dp_n_d, fs_q, fs_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic              slot_end, frame_end, cur_dark, cur_dp;
    logic [3:0]        nib;
    logic [DIGITS-1:0] zero_from, lz_mask, dark;

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

        // A load landing on the boundary still promotes the older shadow first.
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        if (frame_end && pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
        end
        if (load) begin
            shadow_d = '{val: value, dp: dp, blank: blank, lz: lz_en};
            pend_d   = 1'b1;
        end
    end

    always_comb begin
        // zero_from[d]: every nibble from d up to the leftmost digit is zero
        zero_from = '0;
        zero_from[DIGITS-1] = (active_q.val[DIGITS-1] == 4'h0);
        for (int d = DIGITS - 2; d >= 0; d--)
            zero_from[d] = zero_from[d+1] && (active_q.val[d] == 4'h0);
        lz_mask    = zero_from;
        lz_mask[0] = 1'b0;
        dark       = active_q.blank | ({DIGITS{active_q.lz}} & lz_mask);

        nib      = '0;
        cur_dark = 1'b0;
        cur_dp   = 1'b0;
        seg_d    = 7'h7F;
        dp_n_d   = 1'b1;
        an_d     = '1;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx_q == IW'(d)) begin
                nib      = active_q.val[d];
                cur_dark = dark[d];
                cur_dp   = active_q.dp[d];
                if (cnt_q >= BLANK_LIM) an_d[d] = 1'b0;
            end
        end
        if (cnt_q >= BLANK_LIM && !cur_dark) begin
            seg_d  = glyph(nib);
            dp_n_d = ~cur_dp;
        end
        fs_d = (cnt_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
            seg_q    <= 7'h7F;
            dp_n_q   <= 1'b1;
            an_q     <= '1;
            fs_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            seg_q    <= seg_d;
            dp_n_q   <= dp_n_d;
            an_q     <= an_d;
            fs_q     <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp_n        = dp_n_q;
    assign an          = an_q;
    assign frame_start = fs_q;
endmodule
